// File: rtl/scan_signature_analyzer.sv
// scan_signature_analyzer: serial-input signature register (SISR) that compacts scan-chain
// response bits and compares the final signature against a golden value.
// Optional X-masking input scan_mask is present only when SIG_X_MASK_EN is defined.
module scan_signature_analyzer #(
    parameter int               SIG_W      = 16,
    parameter logic [SIG_W-1:0] POLY       = SIG_W'(16'h1021),
    parameter logic [SIG_W-1:0] SEED       = '0,
    parameter int               CNT_W      = 16,
    parameter int               FLUSH_BITS = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] length,
    input  logic [SIG_W-1:0] expected_sig,
    input  logic             scan_out,
    input  logic             scan_valid,
`ifdef SIG_X_MASK_EN
    input  logic             scan_mask,
`endif
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature
);

    typedef enum logic [1:0] {IDLE, FLUSH, COMPACT} state_t;

    // The chain-fill phase is skipped entirely when there is nothing to discard.
    localparam state_t           RUN_ENTRY  = (FLUSH_BITS > 0) ? FLUSH : COMPACT;
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_BITS - 1);

    state_t           state_q, state_d;
    logic [SIG_W-1:0] sig_q, sig_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [SIG_W-1:0] exp_q, exp_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             bit_in;
    logic [SIG_W-1:0] sig_next;

`ifdef SIG_X_MASK_EN
    // Masked (unknown) response bits enter the SISR as 0 but still count toward length.
    assign bit_in = scan_out & ~scan_mask;
`else
    assign bit_in = scan_out;
`endif

    // One SISR step: shift left, fold the polynomial back in on MSB overflow, inject the bit.
    always_comb begin
        sig_next = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ {{(SIG_W-1){1'b0}}, bit_in};
    end

    // Next-state logic for the run controller, counter and result registers.
    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        exp_d   = exp_q;
        pass_d  = pass_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    len_d  = length;
                    exp_d  = expected_sig;
                    sig_d  = SEED;
                    cnt_d  = '0;
                    pass_d = 1'b0;
                    if (length == '0) begin
                        done_d = 1'b1;
                        pass_d = (SEED == expected_sig);
                    end else begin
                        state_d = RUN_ENTRY;
                    end
                end
            end
            FLUSH: begin
                if (scan_valid) begin
                    cnt_d   = (cnt_q == FLUSH_LAST) ? '0 : cnt_q + CNT_W'(1);
                    state_d = (cnt_q == FLUSH_LAST) ? COMPACT : FLUSH;
                end
            end
            COMPACT: begin
                if (scan_valid) begin
                    sig_d = sig_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == len_q - CNT_W'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        pass_d  = (sig_next == exp_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset aborts any run without a done pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            sig_q   <= SEED;
            cnt_q   <= '0;
            len_q   <= '0;
            exp_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            exp_q   <= exp_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign signature = sig_q;

endmodule

// File: tb/tb_scan_signature_analyzer.sv
// tb_scan_signature_analyzer: randomized bench for scan_signature_analyzer, driving a default
// instance and a FLUSH_BITS=3 instance from one shared response stream.
module tb_scan_signature_analyzer;

`ifdef SIG_X_MASK_EN
    localparam bit MASK_EN = 1'b1;
`else
    localparam bit MASK_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] length;
    logic [15:0] expected_sig;
    logic        scan_out;
    logic        scan_valid;
    logic        scan_mask;
    logic        busy0, done0, pass0, busy1, done1, pass1;
    logic [15:0] sig0, sig1;
    int          total = 0;
    int          bad = 0;

    always #5 clock = ~clock;

    scan_signature_analyzer dut0 (
        .clock(clock), .reset(reset), .start(start), .length(length),
        .expected_sig(expected_sig), .scan_out(scan_out), .scan_valid(scan_valid),
`ifdef SIG_X_MASK_EN
        .scan_mask(scan_mask),
`endif
        .busy(busy0), .done(done0), .pass(pass0), .signature(sig0)
    );

    scan_signature_analyzer #(.FLUSH_BITS(3)) dut1 (
        .clock(clock), .reset(reset), .start(start), .length(length),
        .expected_sig(expected_sig), .scan_out(scan_out), .scan_valid(scan_valid),
`ifdef SIG_X_MASK_EN
        .scan_mask(scan_mask),
`endif
        .busy(busy1), .done(done1), .pass(pass1), .signature(sig1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
        end
    endtask

    // Signature arithmetic with POLY=0x1021 over 16 bits, written as plain integer math.
    function automatic int sisr(input int s, input int b);
        return ((s * 2) % 65536) ^ ((s >= 32768) ? 'h1021 : 0) ^ b;
    endfunction

    // One run: dut0 compacts the first L valid bits, dut1 discards 3 then compacts the next L.
    task automatic run_case(input int L, input int E, input int dense, input logic [31:0] pat,
                            input int use_pat, input int want0);
        int   k, e0, e1, p0, p1, cyc;
        logic v, b, m;
        k = 0; e0 = 0; e1 = 0; p0 = 0; p1 = 0;
        start = 1'b1; length = 16'(L); expected_sig = 16'(E); scan_valid = 1'b0;
        @(posedge clock); #1;
        start = 1'b0;
        check("start_busy0", busy0, L != 0);
        check("start_busy1", busy1, L != 0);
        check("start_done0", done0, L == 0);
        check("start_done1", done1, L == 0);
        check("start_pass0", pass0, (L == 0) && (E == 0));
        check("start_pass1", pass1, (L == 0) && (E == 0));
        check("start_sig0", sig0, 0);
        check("start_sig1", sig1, 0);
        if (L == 0) begin
            @(posedge clock); #1;
            check("len0_done0_clr", done0, 0);
            check("len0_busy0", busy0, 0);
            check("len0_pass0_hold", pass0, E == 0);
            return;
        end
        for (cyc = 0; cyc < 4000 && k < L + 3; cyc++) begin
            v = dense != 0 ? 1'b1 : ($urandom_range(0, 3) != 0);
            b = use_pat != 0 ? pat[k % 32] : 1'($urandom);
            m = MASK_EN ? 1'($urandom) : 1'b0;
            start = (k < L) && ($urandom_range(0, 7) == 0);
            scan_valid = v; scan_out = b; scan_mask = m;
            @(posedge clock); #1;
            if (v) begin
                k++;
                if (k <= L) e0 = sisr(e0, b & ~m);
                if (k > 3) e1 = sisr(e1, b & ~m);
                if (k == L) p0 = (e0 == E);
                if (k == L + 3) p1 = (e1 == E);
            end
            check("sig0", sig0, e0);
            check("done0", done0, v && k == L);
            check("busy0", busy0, k < L);
            check("pass0", pass0, p0);
            check("sig1", sig1, e1);
            check("done1", done1, v && k == L + 3);
            check("busy1", busy1, k < L + 3);
            check("pass1", pass1, p1);
        end
        if (k < L + 3) check("timeout", k, L + 3);
        start = 1'b0; scan_valid = 1'b0;
        @(posedge clock); #1;
        check("end_done0", done0, 0);
        check("end_done1", done1, 0);
        check("end_sig0", sig0, e0);
        check("end_sig1", sig1, e1);
        check("end_pass0", pass0, p0);
        check("end_pass1", pass1, p1);
        if (want0 >= 0) check("golden_sig0", sig0, want0);
    endtask

    task automatic reset_mid_run();
        start = 1'b1; length = 16'd20; expected_sig = 16'h0; scan_mask = 1'b0;
        @(posedge clock); #1;
        start = 1'b0; scan_valid = 1'b1; scan_out = 1'b1;
        repeat (6) @(posedge clock);
        #1;
        check("pre_reset_busy0", busy0, 1);
        check("pre_reset_sig0", sig0, 16'h003f);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("rst_sig0", sig0, 0);
        check("rst_sig1", sig1, 0);
        check("rst_busy0", busy0, 0);
        check("rst_busy1", busy1, 0);
        check("rst_done0", done0, 0);
        check("rst_pass0", pass0, 0);
        repeat (3) begin
            @(posedge clock); #1;
            check("post_rst_done0", done0, 0);
            check("post_rst_done1", done1, 0);
            check("post_rst_sig0", sig0, 0);
        end
        scan_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; length = '0; expected_sig = '0;
        scan_out = 1'b0; scan_valid = 1'b0; scan_mask = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_busy", busy0, 0);
        check("reset_done", done0, 0);
        check("reset_pass", pass0, 0);
        check("reset_sig", sig0, 0);
        check("reset_busy1", busy1, 0);
        reset = 1'b0;
        @(posedge clock); #1;
        run_case(1, 'h0001, 1, 32'h1, 1, MASK_EN ? -1 : 'h0001);
        run_case(17, 'h1021, 1, 32'h1, 1, MASK_EN ? -1 : 'h1021);
        run_case(17, 'h1020, 1, 32'h1, 1, -1);
        run_case(2, 'h0003, 0, 32'h3, 1, -1);
        run_case(1, 'h0000, 1, 32'h7, 1, -1);
        run_case(0, 'h0000, 1, 32'h0, 1, -1);
        run_case(0, 'h1234, 1, 32'h0, 1, -1);
        reset_mid_run();
        for (int i = 0; i < 25; i++)
            run_case($urandom_range(1, 40), $urandom_range(0, 65535), 0, 32'h0, 0, -1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
